command_arbiter: RTL

- Round-robin arbiter that shares the single AFU command buffer port among NUM_REQ requesters: the WED fetch control plus the compute units.
- Each requester presents a CommandBufferLine with valid and receives a one-cycle grant pulse.
- Winning commands are registered onto command_out.
- Throttles issue on command_buffer_status.alfull and on an outstanding-command credit limit, which is replenished by PSL responses.

---
 rtl/command_arbiter_if.sv | 61 ++++++
 rtl/command_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/command_arbiter_if.sv
// command_arbiter_if: shared types and the requester/command-buffer bundle for command_arbiter
// Optional stats port appears when CMD_ARBITER_STATS_EN is defined.
package command_arbiter_pkg;
    typedef enum logic [3:0] {INVALID, READ_CL_NA, READ_CL_S, WRITE_NA, WRITE_MI} afu_command_t;
    typedef enum logic [2:0] {STRICT, ABORT, PAGE, PREF, SPEC} trans_order_t;
    typedef enum logic [1:0] {CMD_INVALID, CMD_WED, CMD_READ, CMD_WRITE} cmd_type_t;
    typedef enum logic [1:0] {ARB_RESET, ARB_IDLE, ARB_RUN, ARB_DRAIN} arb_state_t;
    localparam logic [7:0] INVALID_ID = 8'hFF;
    typedef struct packed {
        logic [7:0] cu_id;
        cmd_type_t  cmd_type;
    } CommandTag;
    typedef struct packed {
        logic         valid;
        afu_command_t command;
        logic [63:0]  address;
        logic [11:0]  size;
        trans_order_t abt;
        CommandTag    cmd;
    } CommandBufferLine;
    typedef struct packed {
        logic alfull;
    } BufferStatus;
    typedef struct packed {
        logic valid;
    } ResponseBufferLine;
    localparam CommandBufferLine CMD_RESET = '{valid: 1'b0, command: INVALID, address: 64'd0, size: 12'd0,
                                               abt: STRICT, cmd: '{cu_id: INVALID_ID, cmd_type: CMD_INVALID}};
`ifdef CMD_ARBITER_STATS_EN
    typedef struct packed {
        logic [31:0] issued_count;
        logic [31:0] stall_count;
    } ArbiterStats;
`endif
endpackage

interface command_arbiter_if import command_arbiter_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 7
);
    logic                 enabled_in;
    CommandBufferLine     command_in [NUM_REQ];
    BufferStatus          command_buffer_status;
    ResponseBufferLine    response_in;
    logic [NUM_REQ-1:0]   grant_out;
    CommandBufferLine     command_out;
    logic [CNT_W-1:0]     outstanding_out;
    logic                 idle_out;
`ifdef CMD_ARBITER_STATS_EN
    ArbiterStats          stats_out;
    modport master (output enabled_in, command_in, command_buffer_status, response_in,
                    input grant_out, command_out, outstanding_out, idle_out, stats_out);
    modport slave  (input enabled_in, command_in, command_buffer_status, response_in,
                    output grant_out, command_out, outstanding_out, idle_out, stats_out);
`else
    modport master (output enabled_in, command_in, command_buffer_status, response_in,
                    input grant_out, command_out, outstanding_out, idle_out);
    modport slave  (input enabled_in, command_in, command_buffer_status, response_in,
                    output grant_out, command_out, outstanding_out, idle_out);
`endif
endinterface

// File: rtl/command_arbiter.sv
// command_arbiter: round-robin arbiter for the AFU command buffer with alfull and credit throttling
// Define CMD_ARBITER_STATS_EN to add issued/stall counters on stats_out.
module command_arbiter import command_arbiter_pkg::*; #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 64,
    parameter int CNT_W           = 7
) (
    input  logic            clock,
    input  logic            rstn,
    command_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state, w_next;
    logic               r_en;
    logic [PTR_W-1:0]   r_ptr, w_ptr_next, w_win, w_idx;
    logic [CNT_W-1:0]   r_cnt;
    CommandBufferLine   r_cmd, w_sel;
    logic [NUM_REQ-1:0] w_valid, w_grant;
    logic               w_found, w_issue, w_resp;

    // gather request valids from the per-requester lines
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) w_valid[i] = bus.command_in[i].valid;
    end

    // first valid requester at or above the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // mux out the winning command line
    always_comb begin
        w_sel = CMD_RESET;
        for (int i = 0; i < NUM_REQ; i++) if (PTR_W'(i) == w_win) w_sel = bus.command_in[i];
    end

    // issue gating, grant vector, credit return and pointer advance
    always_comb begin
        w_issue    = r_state == ARB_RUN && w_found && !bus.command_buffer_status.alfull &&
                     r_cnt < CNT_W'(MAX_OUTSTANDING);
        w_grant    = w_issue ? NUM_REQ'(1) << w_win : '0;
        w_resp     = bus.response_in.valid && r_cnt != '0;
        w_ptr_next = w_issue ? (w_win == PTR_W'(NUM_REQ - 1) ? '0 : w_win + 1'b1) : r_ptr;
    end

    // next-state: drain keeps retiring responses and can resume if re-enabled
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_RESET: w_next = ARB_IDLE;
            ARB_IDLE:  w_next = r_en ? ARB_RUN : ARB_IDLE;
            ARB_RUN:   w_next = r_en ? ARB_RUN : ARB_DRAIN;
            ARB_DRAIN: w_next = r_en ? ARB_RUN : (r_cnt == '0 ? ARB_IDLE : ARB_DRAIN);
            default:   w_next = ARB_RESET;
        endcase
    end

    assign bus.grant_out       = w_grant;
    assign bus.command_out     = r_cmd;
    assign bus.outstanding_out = r_cnt;
    assign bus.idle_out        = r_state == ARB_IDLE && r_cnt == '0;

    // state, registered enable, pointer, credits and the output command register
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state <= ARB_RESET;
            r_en    <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_cmd   <= CMD_RESET;
        end else begin
            r_state <= w_next;
            r_en    <= bus.enabled_in;
            r_ptr   <= w_ptr_next;
            r_cnt   <= r_cnt + CNT_W'(w_issue) - CNT_W'(w_resp);
            if (w_issue) r_cmd <= w_sel;
            else r_cmd.valid <= 1'b0;
        end
    end

`ifdef CMD_ARBITER_STATS_EN
    logic [31:0] r_issued, r_stall;

    // saturating counts of grants and of throttled request cycles
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_issued <= '0;
            r_stall  <= '0;
        end else begin
            if (w_issue && r_issued != '1) r_issued <= r_issued + 32'd1;
            if (r_state == ARB_RUN && w_found && !w_issue && r_stall != '1) r_stall <= r_stall + 32'd1;
        end
    end

    assign bus.stats_out = '{issued_count: r_issued, stall_count: r_stall};
`endif
endmodule
